unidade_controle: RTL and testbench

//  Multicycle fetch/decode/execute sequencer that drives the 8-bit ALU and writes its result back.

---
 rtl/unidade_controle.sv | 166 ++++++++++++++++
 tb/tb_unidade_controle.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// Multicycle fetch/decode/execute sequencer driving an external 8-bit ALU and
// writing its result back into an accumulator with zero and divide-by-zero status.
module unidade_controle #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [7:0]        alu_result,
    output logic [7:0]        acc_out,
    output logic              zero_flag,
    output logic              div_zero,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_LDI  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_JZ   = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic [7:0]        acc_q, acc_d;
    logic              zero_q, zero_d;
    logic              divz_q, divz_d;
    logic [7:0]        aluA_q, aluA_d;
    logic [7:0]        aluB_q, aluB_d;
    logic [3:0]        aluOp_q, aluOp_d;

    logic [3:0]        irOp;
    logic [7:0]        irImm;
    logic              irIsAlu;
    logic [ADDR_W-1:0] jumpTarget;
    logic              unused_reserved;

    assign irOp            = ir_q[15:12];
    assign irImm           = ir_q[7:0];
    assign irIsAlu         = (irOp != 4'h0) && (irOp <= 4'hB);
    assign jumpTarget      = ADDR_W'(irImm);
    assign unused_reserved = ^ir_q[11:8];

    // Reset clears everything at once, so an interrupted instruction leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            acc_q   <= '0;
            zero_q  <= 1'b0;
            divz_q  <= 1'b0;
            aluA_q  <= '0;
            aluB_q  <= '0;
            aluOp_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            zero_q  <= zero_d;
            divz_q  <= divz_d;
            aluA_q  <= aluA_d;
            aluB_q  <= aluB_d;
            aluOp_q <= aluOp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        zero_d  = zero_q;
        divz_d  = divz_q;
        aluA_d  = aluA_q;
        aluB_d  = aluB_q;
        aluOp_d = aluOp_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = imem_data;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Division by zero is trapped here so the ALU never sees it.
                if (irOp == OP_DIV && irImm == 8'h00) begin
                    divz_d  = 1'b1;
                    aluOp_d = 4'h0;
                    state_d = S_FETCH;
                end else if (irIsAlu) begin
                    aluA_d  = acc_q;
                    aluB_d  = irImm;
                    aluOp_d = irOp;
                    state_d = S_WRITE;
                end else begin
                    aluOp_d = 4'h0;
                    state_d = S_FETCH;
                    case (irOp)
                        OP_LDI: begin
                            acc_d  = irImm;
                            zero_d = (irImm == 8'h00);
                        end
                        OP_JMP:  pc_d = jumpTarget;
                        OP_JZ:   if (zero_q) pc_d = jumpTarget;
                        OP_HALT: state_d = S_HALT;
                        default: ;
                    endcase
                end
            end
            S_WRITE: begin
                acc_d   = alu_result;
                zero_d  = (alu_result == 8'h00);
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    pc_d    = PC_RESET;
                    acc_d   = '0;
                    zero_d  = 1'b0;
                    divz_d  = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                 (state_q == S_EXEC)  || (state_q == S_WRITE);
        halted = (state_q == S_HALT);
    end

    assign imem_addr  = pc_q;
    assign alu_a      = aluA_q;
    assign alu_b      = aluB_q;
    assign alu_opcode = aluOp_q;
    assign acc_out    = acc_q;
    assign zero_flag  = zero_q;
    assign div_zero   = divz_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: behavioural ALU and instruction memories, an
// instruction-level reference model feeding a scoreboard, and directed tests.
module tb_unidade_controle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start4;
    logic [7:0]  imemAddr;
    logic [15:0] imemData;
    logic [7:0]  aluA, aluB, aluResult, accOut;
    logic [3:0]  aluOpcode;
    logic        zeroFlag, divZero, busy, halted;

    logic [3:0]  imemAddr4;
    logic [15:0] imemData4;
    logic [7:0]  aluA4, aluB4, aluResult4, accOut4;
    logic [3:0]  aluOpcode4;
    logic        zeroFlag4, divZero4, busy4, halted4;

    logic [15:0] mem  [256];
    logic [15:0] mem4 [16];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] fetchAddr;
        int         cycles;
        bit         isAlu;
        logic [7:0] opA;
        logic [7:0] opB;
        logic [3:0] opCode;
        logic [7:0] pcAfter;
        logic [7:0] acc;
        bit         zf;
        bit         dz;
        bit         hlt;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] addr4Q[$];

    always #5 clk = ~clk;

    unidade_controle #(.ADDR_W(8), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_addr(imemAddr), .imem_data(imemData),
        .alu_a(aluA), .alu_b(aluB), .alu_opcode(aluOpcode), .alu_result(aluResult),
        .acc_out(accOut), .zero_flag(zeroFlag), .div_zero(divZero),
        .busy(busy), .halted(halted)
    );

    unidade_controle #(.ADDR_W(4), .RESET_PC(0)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .imem_addr(imemAddr4), .imem_data(imemData4),
        .alu_a(aluA4), .alu_b(aluB4), .alu_opcode(aluOpcode4), .alu_result(aluResult4),
        .acc_out(accOut4), .zero_flag(zeroFlag4), .div_zero(divZero4),
        .busy(busy4), .halted(halted4)
    );

    // Bench-side ALU: 8-bit truncating results for every op code.
    function automatic logic [7:0] aluFn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'h1:    return a + b;
            4'h2:    return a - b;
            4'h3:    return a * b;
            4'h4:    return (b == 8'h00) ? 8'hFF : a / b;
            4'h5:    return a & b;
            4'h6:    return a | b;
            4'h7:    return a ^ b;
            4'h8:    return a << b[2:0];
            4'h9:    return a >> b[2:0];
            4'hA:    return ~(a & b);
            4'hB:    return (a == b) ? 8'h01 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    assign aluResult  = aluFn(aluA, aluB, aluOpcode);
    assign aluResult4 = aluFn(aluA4, aluB4, aluOpcode4);

    always @(posedge clk) imemData  <= mem[imemAddr];
    always @(posedge clk) imemData4 <= mem4[imemAddr4];

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [7:0] imm);
        return {op, 4'h0, imm};
    endfunction

    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Instruction-level model of the program in mem, starting from a cleared machine.
    task automatic buildExpect();
        logic [7:0] pc, acc, imm;
        logic [3:0] op;
        bit         zf, dz;
        exp_t       e;
        pc = 8'h00; acc = 8'h00; zf = 1'b0; dz = 1'b0;
        for (int n = 0; n < 64; n++) begin
            op = mem[pc][15:12];
            imm = mem[pc][7:0];
            e.fetchAddr = pc; e.cycles = 3; e.isAlu = 1'b0; e.hlt = 1'b0;
            e.opA = 8'h00; e.opB = 8'h00; e.opCode = 4'h0;
            pc = pc + 8'd1;
            if (op == 4'h4 && imm == 8'h00) begin
                dz = 1'b1;
            end else if (op >= 4'h1 && op <= 4'hB) begin
                e.isAlu = 1'b1; e.cycles = 4;
                e.opA = acc; e.opB = imm; e.opCode = op;
                acc = aluFn(acc, imm, op);
                zf = (acc == 8'h00);
            end else begin
                case (op)
                    4'hC: begin acc = imm; zf = (imm == 8'h00); end
                    4'hD: pc = imm;
                    4'hE: if (zf) pc = imm;
                    4'hF: e.hlt = 1'b1;
                    default: ;
                endcase
            end
            e.pcAfter = pc; e.acc = acc; e.zf = zf; e.dz = dz;
            sb.push_back(e);
            if (e.hlt) break;
        end
    endtask

    // Starts the program in mem and checks each instruction against the scoreboard.
    task automatic runProgram(input string tag, input bit glitch);
        exp_t e;
        bit   glitchDone;
        glitchDone = 1'b0;
        buildExpect();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (accOut !== 8'h00) begin errors++; $display("[TB] FAIL %s start_acc got %h expected 00", tag, accOut); end
        checks++;
        if (divZero !== 1'b0) begin errors++; $display("[TB] FAIL %s start_divzero got %b expected 0", tag, divZero); end
        checks++;
        if (zeroFlag !== 1'b0) begin errors++; $display("[TB] FAIL %s start_zero got %b expected 0", tag, zeroFlag); end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (imemAddr !== e.fetchAddr || busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s fetch addr/busy got %h/%b expected %h/1", tag, imemAddr, busy, e.fetchAddr);
            end
            for (int c = 1; c <= e.cycles; c++) begin
                @(negedge clk);
                if (glitch && !glitchDone && c == 1) start = 1'b1;
                if (glitch && !glitchDone && c == 2) begin start = 1'b0; glitchDone = 1'b1; end
                if (e.isAlu && c == 3) begin
                    checks++;
                    if (aluA !== e.opA || aluB !== e.opB || aluOpcode !== e.opCode) begin
                        errors++;
                        $display("[TB] FAIL %s alu_operands@%h got a=%h b=%h op=%h expected a=%h b=%h op=%h",
                                 tag, e.fetchAddr, aluA, aluB, aluOpcode, e.opA, e.opB, e.opCode);
                    end
                end
            end
            checks++;
            if (accOut !== e.acc) begin errors++; $display("[TB] FAIL %s acc@%h got %h expected %h", tag, e.fetchAddr, accOut, e.acc); end
            checks++;
            if (zeroFlag !== e.zf) begin errors++; $display("[TB] FAIL %s zero@%h got %b expected %b", tag, e.fetchAddr, zeroFlag, e.zf); end
            checks++;
            if (divZero !== e.dz) begin errors++; $display("[TB] FAIL %s divzero@%h got %b expected %b", tag, e.fetchAddr, divZero, e.dz); end
            checks++;
            if (halted !== e.hlt || busy !== !e.hlt) begin
                errors++;
                $display("[TB] FAIL %s halted/busy@%h got %b/%b expected %b/%b", tag, e.fetchAddr, halted, busy, e.hlt, !e.hlt);
            end
            checks++;
            if (imemAddr !== e.pcAfter) begin errors++; $display("[TB] FAIL %s next_addr@%h got %h expected %h", tag, e.fetchAddr, imemAddr, e.pcAfter); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({aluA, aluB, aluOpcode, accOut, zeroFlag, divZero} !== 30'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got a=%h b=%h op=%h acc=%h z=%b dz=%b expected all 0",
                     aluA, aluB, aluOpcode, accOut, zeroFlag, divZero);
        end
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || imemAddr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_state got busy=%b halted=%b addr=%h expected 0/0/00", busy, halted, imemAddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_without_start busy got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_exec();
        clearMem();
        mem[0] = mk(4'hC, 8'h07);
        mem[1] = mk(4'h1, 8'h03);
        mem[2] = mk(4'hF, 8'h00);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({aluA, aluB, aluOpcode, accOut, zeroFlag, divZero} !== 30'h0) begin
            errors++;
            $display("[TB] FAIL midexec_reset_outputs got a=%h b=%h op=%h acc=%h expected all 0", aluA, aluB, aluOpcode, accOut);
        end
        checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || imemAddr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midexec_reset_state got busy=%b halted=%b addr=%h expected 0/0/00", busy, halted, imemAddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (accOut !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midexec_no_writeback got acc=%h busy=%b expected 00/0", accOut, busy);
        end
    endtask

    task automatic test_alu_program();
        doReset();
        clearMem();
        mem[0] = mk(4'hC, 8'h05);
        mem[1] = mk(4'h1, 8'h03);
        mem[2] = mk(4'h2, 8'h08);
        mem[3] = mk(4'hF, 8'h00);
        runProgram("alu_program", 1'b0);
    endtask

    task automatic test_div_zero();
        doReset();
        clearMem();
        mem[0] = mk(4'hC, 8'h09);
        mem[1] = mk(4'h4, 8'h00);
        mem[2] = mk(4'hC, 8'h02);
        mem[3] = mk(4'hF, 8'h00);
        runProgram("div_zero", 1'b0);
    endtask

    task automatic test_jz();
        doReset();
        clearMem();
        mem[8'h00] = mk(4'hC, 8'h00);
        mem[8'h01] = mk(4'hE, 8'h10);
        mem[8'h10] = mk(4'hC, 8'h01);
        mem[8'h11] = mk(4'hE, 8'h20);
        mem[8'h12] = mk(4'hD, 8'h30);
        mem[8'h30] = mk(4'hF, 8'h00);
        runProgram("jz", 1'b0);
    endtask

    task automatic test_mul_trunc();
        doReset();
        clearMem();
        mem[0] = mk(4'hC, 8'h20);
        mem[1] = mk(4'h3, 8'h10);
        mem[2] = mk(4'hF, 8'h00);
        runProgram("mul_trunc", 1'b0);
    endtask

    task automatic test_alu_mix();
        doReset();
        clearMem();
        mem[0]  = mk(4'hC, 8'h3C);
        mem[1]  = mk(4'h5, 8'h0F);
        mem[2]  = mk(4'h6, 8'h80);
        mem[3]  = mk(4'h7, 8'hFF);
        mem[4]  = mk(4'h8, 8'h01);
        mem[5]  = mk(4'h9, 8'h02);
        mem[6]  = mk(4'hA, 8'hF0);
        mem[7]  = mk(4'hB, 8'hCF);
        mem[8]  = mk(4'h4, 8'h03);
        mem[9]  = {4'h1, 4'hA, 8'hFF};
        mem[10] = mk(4'hF, 8'h00);
        runProgram("alu_mix", 1'b0);
    endtask

    task automatic test_start_while_busy();
        doReset();
        clearMem();
        mem[0] = mk(4'hC, 8'h09);
        mem[1] = mk(4'h4, 8'h00);
        mem[2] = mk(4'h1, 8'h01);
        mem[3] = mk(4'hF, 8'h00);
        runProgram("start_while_busy", 1'b1);
    endtask

    task automatic test_restart_from_halt();
        clearMem();
        mem[0] = mk(4'h1, 8'h04);
        mem[1] = mk(4'hF, 8'h00);
        runProgram("restart_from_halt", 1'b0);
    endtask

    task automatic test_pc_wrap();
        for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
        mem4[0] = mk(4'hD, 8'hFE);
        addr4Q.push_back(4'h0);
        addr4Q.push_back(4'hE);
        addr4Q.push_back(4'hF);
        addr4Q.push_back(4'h0);
        addr4Q.push_back(4'hE);
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        while (addr4Q.size() > 0) begin
            logic [3:0] want;
            want = addr4Q.pop_front();
            checks++;
            if (imemAddr4 !== want || busy4 !== 1'b1) begin
                errors++;
                $display("[TB] FAIL pc_wrap fetch got %h/%b expected %h/1", imemAddr4, busy4, want);
            end
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_alu_program();
        test_div_zero();
        test_jz();
        test_mul_trunc();
        test_alu_mix();
        test_start_while_busy();
        test_restart_from_halt();
        test_pc_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
